// File: rtl/fifo_uart_tx.sv
// Pops bytes from a show-ahead FIFO and serialises them as UART 8N1, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_dout,
    output logic             fifo_re,
    output logic             txd,
    output logic             busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pop_c, done_c, baud_last;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            cnt_q   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            cnt_q   <= cnt_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        cnt_d   = cnt_q;
        pop_c   = 1'b0;
        done_c  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) begin
            baud_d = baud_last ? '0 : baud_q + BAUD_ONE;
        end
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (enable && !fifo_empty) begin
                    // Latch the show-ahead byte on the same edge that pops it.
                    pop_c   = 1'b1;
                    shift_d = fifo_dout;
                    txd_d   = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
`ifdef FIFO_UART_TX_PARITY_EN
                    par_d   = ^fifo_dout;
`endif
                end
            end
            START: begin
                if (baud_last) begin
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        txd_d   = par_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    txd_d   = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    done_c  = 1'b1;
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = IDLE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // The async reset already forces IDLE, so the pop must also be masked by srst.
    assign fifo_re   = pop_c & ~srst;
    assign txd       = txd_q;
    assign busy      = (state_q != IDLE);
    assign tx_done   = done_c;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a small behavioural FIFO.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic        clk = 1'b0;
    logic        srst, enable, fifo_re, txd, busy, tx_done;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [15:0] frame_cnt;

    logic [7:0]  mem [0:15];
    int          rd = 0, wr = 0;
    int          re_cnt = 0, done_cnt = 0;
    int          errs = 0, nchk = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd == wr);
    assign fifo_dout  = mem[rd[3:0]];

    always @(posedge clk) begin
        if (fifo_re) begin
            rd       <= rd + 1;
            re_cnt   <= re_cnt + 1;
        end
        if (tx_done) done_cnt <= done_cnt + 1;
    end

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk(clk), .srst(srst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_re(fifo_re), .txd(txd), .busy(busy),
        .tx_done(tx_done), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        nchk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr[3:0]] = b;
        wr = wr + 1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && NBITS == 11) return ^b;
        return 1'b1;
    endfunction

    // Entered at a negedge in the IDLE cycle that pops b; returns at the
    // negedge of the last stop cycle (or right after an abort).
    task automatic send_frame(input logic [7:0] b, input int drop_at, input int abort_at);
        chk("pop", fifo_re, 1);
        chk("idle_txd", txd, 1);
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            chk($sformatf("txd_%02h_c%0d", b, c), txd, exp_bit(b, c / CPB));
            chk($sformatf("done_%02h_c%0d", b, c), tx_done, (c == FRAME - 1) ? 1 : 0);
            chk($sformatf("busy_%02h_c%0d", b, c), busy, 1);
            if (c > 0) chk($sformatf("nopop_%02h_c%0d", b, c), fifo_re, 0);
            if (c == drop_at) enable = 1'b0;
            if (c == abort_at) begin
                srst = 1'b1;
                #1;
                chk("abort_txd", txd, 1);
                chk("abort_busy", busy, 0);
                chk("abort_cnt", frame_cnt, 0);
                chk("abort_done", tx_done, 0);
                chk("abort_re", fifo_re, 0);
                return;
            end
        end
    endtask

    initial begin
        int bad_re, bad_txd;
        srst   = 1'b1;
        enable = 1'b1;
        push(8'hA5);
        // T1: reset holds everything quiet even with data available
        repeat (2) @(negedge clk);
        chk("rst_re", fifo_re, 0);
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_done", tx_done, 0);
        srst = 1'b0;
        #1;
        chk("rel_re", fifo_re, 1);

        // T2: single 0xA5
        send_frame(8'hA5, -1, -1);
        @(negedge clk);
        chk("t2_busy", busy, 0);
        chk("t2_cnt", frame_cnt, 1);
        chk("t2_re", fifo_re, 0);
        chk("t2_txd", txd, 1);
        chk("t2_recnt", re_cnt, 1);

        // T3: three queued bytes, back-to-back with one idle cycle between
        push(8'h00); push(8'hFF); push(8'h55);
        #1;
        send_frame(8'h00, -1, -1);
        @(negedge clk);
        chk("t3_gap0_busy", busy, 0);
        send_frame(8'hFF, -1, -1);
        @(negedge clk);
        chk("t3_gap1_busy", busy, 0);
        send_frame(8'h55, -1, -1);
        @(negedge clk);
        chk("t3_cnt", frame_cnt, 4);
        chk("t3_empty", fifo_empty, 1);
        chk("t3_recnt", re_cnt, 4);

        // T4: empty FIFO, enabled, nothing happens
        bad_re = 0; bad_txd = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo_re) bad_re++;
            if (!txd) bad_txd++;
        end
        chk("t4_re_cycles", bad_re, 0);
        chk("t4_txd_low", bad_txd, 0);
        chk("t4_recnt", re_cnt, 4);

        // T5: enable drops during data bit 3; remaining bytes wait
        push(8'h3C); push(8'h01); push(8'h22);
        #1;
        send_frame(8'h3C, 17, -1);
        bad_re = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fifo_re || busy) bad_re++;
        end
        chk("t5_held", bad_re, 0);
        chk("t5_cnt", frame_cnt, 5);
        chk("t5_recnt", re_cnt, 5);
        enable = 1'b1;
        #1;
        send_frame(8'h01, -1, -1);
        @(negedge clk);
        send_frame(8'h22, -1, -1);
        @(negedge clk);
        chk("t5_cnt2", frame_cnt, 7);
        chk("t5_recnt2", re_cnt, 7);
        chk("t5_empty", fifo_empty, 1);

        // T6: reset during data bit 5 aborts the frame
        push(8'h5A);
        #1;
        send_frame(8'h5A, -1, 25);
        @(negedge clk);
        srst = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_txd", txd, 1);
        chk("t6_cnt", frame_cnt, 0);
        chk("t6_re", fifo_re, 0);
        repeat (3) @(negedge clk);
        chk("t6_recnt", re_cnt, 8);
        chk("t6_donecnt", done_cnt, 7);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
